round_robin_bus_arbiter: RTL and testbench
==========================================

Name: round_robin_bus_arbiter

Overview:
Sequential round-robin arbiter for the shared snoopy bus between NUMBER_OF_DEVICES cache controllers. It replaces fixed-priority combinational granting with registered, fair, held grants. Each device asserts request and keeps it high for its whole bus tenure. The arbiter holds the grant until the device drops request, or until a hold timeout preempts it while other devices are waiting.

Parameters:
NUMBER_OF_DEVICES, 4, number of requesters; legal range 1..32.
MAX_HOLD_CYCLES, 16, maximum granted cycles before preemption when others are waiting; 0 disables preemption.

Ports:
clock  input  1  single system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
requests  input  NUMBER_OF_DEVICES  request from device i; held high while the device wants or owns the bus.
grants  output  NUMBER_OF_DEVICES  registered grant; at most one bit high (one-hot or zero).
busy  output  1  high whenever any grant bit is high.
owner  output  max(1,$clog2(NUMBER_OF_DEVICES))  index of the granted device; holds the last owner when idle.
preempted  output  1  one-cycle pulse on the cycle a grant is revoked by timeout.

Behaviour:
- Reset (reset high at a clock edge): grants=0, busy=0, owner=NUMBER_OF_DEVICES-1, preempted=0, hold counter=0, state=IDLE.
  - Because owner resets to the last index, the first arbitration after reset starts its search at device 0.
- Reset has priority over everything. Asserting it mid-tenure drops the grant on the next edge. There is no completion handshake.
- States: IDLE, GRANTED.
- IDLE:
  - If any request is high at edge t, pick the first high bit searching from (owner+1) mod N upward with wrap-around.
  - At edge t: grants[winner]=1, owner=winner, counter=0, state=GRANTED.
  - Grant is visible in the cycle after the request is sampled (1-cycle latency).
  - With no requests, remain in IDLE with all outputs stable.
- GRANTED, normal release:
  - If requests[owner]=0 at edge t: grants=0 and state=IDLE.
  - A new grant appears no earlier than edge t+1, giving at least one dead (turnaround) cycle.
  - owner is unchanged, so the next search starts after the released device.
- GRANTED, timeout:
  - If MAX_HOLD_CYCLES>0, counter==MAX_HOLD_CYCLES-1, requests[owner]=1, and any other request is high: at the edge, grants=0, preempted=1 for one cycle, state=IDLE.
  - The preempted device must re-request. It receives no priority and is served last in the round.
- GRANTED, otherwise:
  - Hold the grant and increment the counter, saturating at MAX_HOLD_CYCLES-1.
  - A sole requester is never preempted, even after the counter saturates.
- Simultaneous release and timeout on the same edge: treat as a normal release; preempted stays 0.
- Requests from non-owners during GRANTED are ignored until the next IDLE cycle. There is no queueing and no request latching.
- Counter width: $clog2(MAX_HOLD_CYCLES+1), minimum 1. When MAX_HOLD_CYCLES=0, the counter logic may be optimised away.
- NUMBER_OF_DEVICES=1: degenerates to grant-follows-request with a dead cycle between tenures; preemption is never possible.
- Invariants, asserted in the bench:
  - $onehot0(grants).
  - busy==|grants.
  - preempted implies grants==0 in the same cycle.
  - A grant never changes directly from one device to another without an all-zero cycle in between.

Test Plan:
- Single requester: N=4, reset, then requests=0001 held 3 cycles and dropped -> grants=0001 from cycle 1 to the cycle after the drop, owner=0, then grants=0000.
- Round-robin fairness: requests=1111 held constantly with each winner dropping after 2 cycles -> grant order 0,1,2,3,0, with one idle cycle between tenures.
- Wrap-around search: owner=2 after a release, then requests=0011 -> device 0 granted (search order 3,0,1), not device 1.
- Preemption: MAX_HOLD_CYCLES=4, device 1 holds and device 3 requests -> after 4 granted cycles grants=0000 and preempted=1 for one cycle; next grant=1000 (device 3).
- No preemption when alone: device 2 holds for 40 cycles with no other request -> grants=0100 throughout and preempted never asserts.
- Reset mid-tenure: grants=0010, then reset pulses for 1 cycle -> grants=0000 and owner=3 after the edge; with requests=0110 still high, the next grant is 0010 (device 1).

Source files
------------

// File: rtl/round_robin_bus_arbiter_if.sv
// Snoopy-bus arbitration bundle shared by the cache
// controllers (master) and the round-robin arbiter (slave).
interface round_robin_bus_arbiter_if #(
  parameter int NUMBER_OF_DEVICES = 4
);
  localparam int OW =
    (NUMBER_OF_DEVICES > 1) ? $clog2(NUMBER_OF_DEVICES) : 1;

  logic [NUMBER_OF_DEVICES-1:0] requests;
  logic [NUMBER_OF_DEVICES-1:0] grants;
  logic                         busy;
  logic [OW-1:0]                owner;
  logic                         preempted;

  modport master (
    output requests,
    input  grants,
    input  busy,
    input  owner,
    input  preempted
  );

  modport slave (
    input  requests,
    output grants,
    output busy,
    output owner,
    output preempted
  );
endinterface

// File: rtl/round_robin_bus_arbiter.sv
// Registered round-robin arbiter with held grants, a
// turnaround cycle between tenures and hold-time preemption.
module round_robin_bus_arbiter #(
  parameter int NUMBER_OF_DEVICES = 4,
  parameter int MAX_HOLD_CYCLES   = 16
) (
  input logic                     clock,
  input logic                     reset,
  round_robin_bus_arbiter_if.slave bus
);
  localparam int N  = NUMBER_OF_DEVICES;
  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int CW =
    (MAX_HOLD_CYCLES > 0) ? $clog2(MAX_HOLD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'((MAX_HOLD_CYCLES > 0) ? MAX_HOLD_CYCLES - 1 : 0);

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t        state_q;
  logic [N-1:0]  grants_q;
  logic [OW-1:0] owner_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          preempted_q;

  logic          found_d;
  logic [OW-1:0] winner_d;
  logic [N-1:0]  grant_d;
  logic [OW-1:0] cand;
  logic          others;
  logic          timeout;

  // Search starts just past the last owner and wraps.
  always_comb begin
    found_d  = 1'b0;
    winner_d = owner_q;
    grant_d  = '0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = OW'((int'(owner_q) + k) % N);
      if (!found_d && bus.requests[cand]) begin
        found_d       = 1'b1;
        winner_d      = cand;
        grant_d[cand] = 1'b1;
      end
    end
  end

  assign others  = |(bus.requests & ~grants_q);
  assign timeout = (MAX_HOLD_CYCLES > 0) &&
                   (cnt_q == CNT_MAX) && others;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      grants_q    <= '0;
      owner_q     <= OW'(N - 1);
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      preempted_q <= 1'b0;
    end else begin
      preempted_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            grants_q <= grant_d;
            owner_q  <= winner_d;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= GRANTED;
          end
        end
        GRANTED: begin
          if (!bus.requests[owner_q]) begin
            grants_q <= '0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else if (timeout) begin
            grants_q    <= '0;
            busy_q      <= 1'b0;
            preempted_q <= 1'b1;
            state_q     <= IDLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          grants_q <= '0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.grants    = grants_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
  assign bus.preempted = preempted_q;
endmodule

// File: tb/tb_round_robin_bus_arbiter.sv
// Directed scoreboard bench for the round-robin bus arbiter
// (four devices, four-cycle hold limit).
module tb_round_robin_bus_arbiter;
  localparam int N = 4;

  typedef struct {
    logic [3:0] g;
    logic [1:0] o;
    logic       p;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t sb[$];
  logic [3:0] prev_g;

  round_robin_bus_arbiter_if #(.NUMBER_OF_DEVICES(N)) bus ();

  round_robin_bus_arbiter #(
    .NUMBER_OF_DEVICES(N),
    .MAX_HOLD_CYCLES(4)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle, push what must be seen after the edge.
  task automatic cyc(input logic r,
                     input logic [3:0] req,
                     input logic [3:0] g,
                     input logic [1:0] o,
                     input logic p);
    exp_t e;
    rst          = r;
    bus.requests = req;
    sb.push_back('{g: g, o: o, p: p});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 4'd1, 4'd0);
    end else begin
      e = sb.pop_front();
      chk("grants", bus.grants, e.g);
      chk("busy", {3'b0, bus.busy}, {3'b0, |e.g});
      chk("owner", {2'b0, bus.owner}, {2'b0, e.o});
      chk("preempted", {3'b0, bus.preempted}, {3'b0, e.p});
    end
  endtask

  // Structural invariants on every cycle.
  always @(negedge clk) begin
    if (!$isunknown(bus.grants)) begin
      chk("onehot0", {3'b0, $onehot0(bus.grants)}, 4'd1);
      chk("busy_or", {3'b0, bus.busy}, {3'b0, |bus.grants});
      if (bus.preempted)
        chk("pre_nogrant", bus.grants, 4'd0);
      if (prev_g != 4'd0 && bus.grants != 4'd0)
        chk("no_switch", bus.grants, prev_g);
      prev_g = bus.grants;
    end
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    prev_g       = 4'd0;
    rst          = 1'b1;
    bus.requests = 4'd0;
    @(posedge clk);
    #1;
    // Reset state
    cyc(1, 4'b0000, 4'b0000, 2'd3, 0);
    // Single requester
    cyc(0, 4'b0001, 4'b0001, 2'd0, 0);
    cyc(0, 4'b0001, 4'b0001, 2'd0, 0);
    cyc(0, 4'b0001, 4'b0001, 2'd0, 0);
    cyc(0, 4'b0000, 4'b0000, 2'd0, 0);
    cyc(0, 4'b0000, 4'b0000, 2'd0, 0);
    // Round-robin fairness from reset
    cyc(1, 4'b0000, 4'b0000, 2'd3, 0);
    cyc(0, 4'b1111, 4'b0001, 2'd0, 0);
    cyc(0, 4'b1111, 4'b0001, 2'd0, 0);
    cyc(0, 4'b1110, 4'b0000, 2'd0, 0);
    cyc(0, 4'b1111, 4'b0010, 2'd1, 0);
    cyc(0, 4'b1111, 4'b0010, 2'd1, 0);
    cyc(0, 4'b1101, 4'b0000, 2'd1, 0);
    cyc(0, 4'b1111, 4'b0100, 2'd2, 0);
    cyc(0, 4'b1111, 4'b0100, 2'd2, 0);
    cyc(0, 4'b1011, 4'b0000, 2'd2, 0);
    cyc(0, 4'b1111, 4'b1000, 2'd3, 0);
    cyc(0, 4'b1111, 4'b1000, 2'd3, 0);
    cyc(0, 4'b0111, 4'b0000, 2'd3, 0);
    cyc(0, 4'b1111, 4'b0001, 2'd0, 0);
    cyc(0, 4'b1111, 4'b0001, 2'd0, 0);
    cyc(0, 4'b1110, 4'b0000, 2'd0, 0);
    cyc(0, 4'b0000, 4'b0000, 2'd0, 0);
    // Wrap-around search after owner 2
    cyc(0, 4'b0100, 4'b0100, 2'd2, 0);
    cyc(0, 4'b0000, 4'b0000, 2'd2, 0);
    cyc(0, 4'b0011, 4'b0001, 2'd0, 0);
    cyc(0, 4'b0000, 4'b0000, 2'd0, 0);
    // Preemption of device 1 by waiting device 3
    cyc(0, 4'b0010, 4'b0010, 2'd1, 0);
    cyc(0, 4'b1010, 4'b0010, 2'd1, 0);
    cyc(0, 4'b1010, 4'b0010, 2'd1, 0);
    cyc(0, 4'b1010, 4'b0010, 2'd1, 0);
    cyc(0, 4'b1010, 4'b0000, 2'd1, 1);
    cyc(0, 4'b1010, 4'b1000, 2'd3, 0);
    cyc(0, 4'b0010, 4'b0000, 2'd3, 0);
    cyc(0, 4'b0010, 4'b0010, 2'd1, 0);
    cyc(0, 4'b0000, 4'b0000, 2'd1, 0);
    // Release coinciding with timeout is a plain release
    cyc(0, 4'b0100, 4'b0100, 2'd2, 0);
    cyc(0, 4'b1100, 4'b0100, 2'd2, 0);
    cyc(0, 4'b1100, 4'b0100, 2'd2, 0);
    cyc(0, 4'b1100, 4'b0100, 2'd2, 0);
    cyc(0, 4'b1000, 4'b0000, 2'd2, 0);
    cyc(0, 4'b1000, 4'b1000, 2'd3, 0);
    cyc(0, 4'b0000, 4'b0000, 2'd3, 0);
    // Sole requester is never preempted
    cyc(0, 4'b0100, 4'b0100, 2'd2, 0);
    for (int i = 0; i < 40; i++)
      cyc(0, 4'b0100, 4'b0100, 2'd2, 0);
    cyc(0, 4'b0000, 4'b0000, 2'd2, 0);
    // Reset mid-tenure
    cyc(0, 4'b0110, 4'b0010, 2'd1, 0);
    cyc(0, 4'b0110, 4'b0010, 2'd1, 0);
    cyc(1, 4'b0110, 4'b0000, 2'd3, 0);
    cyc(0, 4'b0110, 4'b0010, 2'd1, 0);
    cyc(0, 4'b0000, 4'b0000, 2'd1, 0);
    cyc(0, 4'b0000, 4'b0000, 2'd1, 0);
    chk("sb_drained", 4'(sb.size()), 4'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
